operand_sequencer: RTL and testbench
====================================

# operand_sequencer

Producer side of the operand interface consumed by the arithmetic block. It debounces the raw step push-button and advances an address counter through the operand ROM, wrapping at a programmable last entry. It performs the one-cycle synchronous ROM read and holds the fetched pair steady on OpA/OpB, with a valid flag, for the arithmetic circuit and LED display. It sits in the top-level entity between the board KEY input, the operand ROM and the arithmetic block.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level change (10 ms at 50 MHz); must be ≥1
- ADDR_W, 4, ROM address width
- LAST_ADDR, 15, highest ROM address used; counter wraps to 0 after it; must be ≤ 2^ADDR_W−1
- clk  input  1  single system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- step_n  input  1  raw, asynchronous, bouncing push-button, active-low (pressed = 0)
- rom_addr  output  ADDR_W  address presented to synchronous operand ROM
- rom_data  input  16  ROM word {OpA[15:8], OpB[7:0]}, valid one clock after rom_addr changes
- OpA  output  8  registered operand A
- OpB  output  8  registered operand B
- valid  output  1  OpA/OpB hold the word for the current rom_addr
- busy  output  1  fetch in progress; steps are not accepted

## Operation
- Input conditioning: step_n passes a 2-flop synchronizer (reset value 1). Debounce counter increments each cycle the synchronized level differs from the debounced level `stable` and clears to 0 whenever they agree. When the count reaches DEBOUNCE_CYCLES, `stable` takes the new level and the counter clears.
- Press pulse: one-cycle pulse in the cycle after `stable` goes 1→0. A release (0→1) produces no pulse. A held button produces exactly one pulse.
- FSM states: FETCH, CAPTURE, IDLE.
- Reset: state=FETCH, rom_addr=0, OpA=0, OpB=0, valid=0, busy=1, stable=1, counter=0, synchronizer=1.
- FETCH lasts one cycle, in which the ROM registers rom_addr. Next state is CAPTURE.
- CAPTURE lasts one cycle. rom_data is valid. At the closing edge, OpA=rom_data[15:8], OpB=rom_data[7:0], valid=1, busy=0, and the next state is IDLE.
- IDLE: on a press pulse, rom_addr=(rom_addr==LAST_ADDR)?0:rom_addr+1, valid=0, busy=1, next state FETCH. Otherwise everything is held.
- OpA/OpB keep their previous values during FETCH/CAPTURE and change only at the CAPTURE edge.
- Press pulses arriving while busy=1 are dropped. They are not queued.
- busy = (state != IDLE). valid is its complement, except that both 0 and 1 states are fully registered as stated above.

## Timing
- Synchronizer latency: 2 cycles.
- Debounce: `stable` changes on the DEBOUNCE_CYCLES-th consecutive disagreeing sample. Any bounce shorter than that restarts the count.
- Let S be the edge where `stable` falls.
  - The press pulse is high in the cycle after S.
  - rom_addr updates, valid falls and busy rises at S+1.
  - State is CAPTURE after S+2.
  - OpA/OpB update and valid rises at S+3.
- After reset is released, valid rises on the 2nd rising edge with reset low, showing the word at address 0.
- Reset asserted in any state, including mid-fetch or mid-debounce, restores all reset values at the next edge. The fetch of address 0 then restarts.

## Test plan
- Reset/boot: ROM[0]=16'hA53C, hold reset 3 cycles, release → valid=0 and busy=1 for 1 cycle, then valid=1, OpA=8'hA5, OpB=8'h3C, rom_addr=0.
- Clean step (DEBOUNCE_CYCLES=4): ROM[1]=16'h0FF0, hold step_n=0 for 20 cycles → exactly one advance, rom_addr=1, OpA=8'h0F, OpB=8'hF0. valid rises 3 edges after `stable` falls, i.e. 2+4+3 cycles after the first low sample.
- Bounce rejection (DEBOUNCE_CYCLES=4): toggle step_n low 3 cycles / high 1 cycle repeatedly for 40 cycles, then release → rom_addr unchanged, valid stays 1.
- Wrap: LAST_ADDR=2, apply 3 clean presses from address 0 → rom_addr sequence 1, 2, 0. OpA/OpB match ROM[1], ROM[2], ROM[0].
- Step during fetch: force a press pulse in the FETCH cycle → it is ignored, and rom_addr advances by exactly 1 for the single accepted press.
- Reset mid-operation: assert reset in the CAPTURE cycle with rom_addr=5 → next edge rom_addr=0, OpA=OpB=0, valid=0. After release, the word at address 0 is presented.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand producer: debounces the step button, walks the operand ROM address
// and presents each fetched {OpA, OpB} pair with a valid flag.
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_W          = 4,
    parameter int LAST_ADDR       = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        OpA,
    output logic [7:0]        OpB,
    output logic              valid,
    output logic              busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {FETCH, CAPTURE, IDLE} state_t;

    logic [1:0]    sync;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;
    logic          press;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any agreeing sample restarts the qualification.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= 2'b11;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            sync     <= {sync[0], step_n};
            stable_d <= stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable_d & ~stable;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        opa_n, opb_n;
    logic              valid_n, busy_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            rom_addr <= '0;
            OpA      <= '0;
            OpB      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_n;
            rom_addr <= addr_n;
            OpA      <= opa_n;
            OpB      <= opb_n;
            valid    <= valid_n;
            busy     <= busy_n;
        end
    end

    // Presses outside IDLE fall through the default hold and are lost.
    always_comb begin
        state_n = state;
        addr_n  = rom_addr;
        opa_n   = OpA;
        opb_n   = OpB;
        valid_n = valid;
        busy_n  = busy;
        case (state)
            FETCH: state_n = CAPTURE;
            CAPTURE: begin
                state_n = IDLE;
                opa_n   = rom_data[15:8];
                opb_n   = rom_data[7:0];
                valid_n = 1'b1;
                busy_n  = 1'b0;
            end
            IDLE: begin
                if (press) begin
                    addr_n  = (rom_addr == ADDR_LAST) ? '0 : rom_addr + 1'b1;
                    valid_n = 1'b0;
                    busy_n  = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomized scoreboard bench for operand_sequencer with a synchronous ROM model.
module tb_operand_sequencer;

    localparam int D    = 4;
    localparam int AW   = 4;
    localparam int LAST = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          step_n = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [7:0]    OpA, OpB;
    logic          valid, busy;

    operand_sequencer #(.DEBOUNCE_CYCLES(D), .ADDR_W(AW), .LAST_ADDR(LAST)) dut (
        .clk(clk), .reset(reset), .step_n(step_n), .rom_addr(rom_addr),
        .rom_data(rom_data), .OpA(OpA), .OpB(OpB), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:15];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   word;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   model_addr = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: each fresh valid presentation must match the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (valid && !prev_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got addr %0h word %0h expected none", rom_addr, {OpA, OpB});
                end else begin
                    e = q.pop_front();
                    chk("sb_addr", 32'(rom_addr), 32'(e.addr));
                    chk("sb_opa", 32'(OpA), 32'(e.word[15:8]));
                    chk("sb_opb", 32'(OpB), 32'(e.word[7:0]));
                end
            end
            prev_valid = valid;
        end
    end

    function automatic int next_addr(input int a);
        return (a == LAST) ? 0 : a + 1;
    endfunction

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        step_n = 1'b1;
        repeat (cycles) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_ops", 32'({OpA, OpB}), 0);
        q.delete();
        model_addr = 0;
        q.push_back('{addr: AW'(0), word: rom[0]});
        reset = 1'b0;
        @(negedge clk);
        chk("boot_valid0", 32'(valid), 0);
        chk("boot_busy1", 32'(busy), 1);
        @(negedge clk);
        chk("boot_valid1", 32'(valid), 1);
        chk("boot_busy0", 32'(busy), 0);
    endtask

    // Clean press held for `hold` cycles; latency counted from the first low drive.
    task automatic press(input int hold);
        int n;
        bit seen;
        logic [15:0] old;
        model_addr = next_addr(model_addr);
        q.push_back('{addr: AW'(model_addr), word: rom[model_addr]});
        old = {OpA, OpB};
        step_n = 1'b0;
        n = 0;
        seen = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (!valid && !seen) begin
                seen = 1;
                chk("ops_held_in_fetch", 32'({OpA, OpB}), 32'(old));
            end
            if (seen && valid) break;
        end
        chk("press_latency", n, 9);
        if (hold > n) repeat (hold - n) @(negedge clk);
        step_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("press_addr", 32'(rom_addr), 32'(model_addr));
        chk("press_valid", 32'(valid), 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        rom[0] = 16'hA53C;
        rom[1] = 16'h0FF0;

        do_reset(3);
        chk("boot_opa", 32'(OpA), 32'h A5);
        chk("boot_opb", 32'(OpB), 32'h 3C);

        press(20);
        chk("step1_opa", 32'(OpA), 32'h0F);
        chk("step1_opb", 32'(OpB), 32'hF0);

        // Bounces shorter than the qualification window never commit.
        for (int i = 0; i < 10; i++) begin
            step_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            step_n = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        step_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("bounce_addr", 32'(rom_addr), 32'(model_addr));
        chk("bounce_valid", 32'(valid), 1);
        chk("bounce_noexp", 32'(q.size()), 0);

        // Random presses spanning the wrap from LAST back to 0.
        for (int i = 0; i < 8; i++) press($urandom_range(12, 20));

        // Reset in the CAPTURE cycle of the fetch of address 5.
        do_reset(2);
        for (int i = 0; i < 4; i++) press($urandom_range(12, 16));
        step_n = 1'b0;
        repeat (8) @(negedge clk);
        chk("midop_addr", 32'(rom_addr), 5);
        chk("midop_valid", 32'(valid), 0);
        chk("midop_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_addr", 32'(rom_addr), 0);
        chk("midrst_ops", 32'({OpA, OpB}), 0);
        chk("midrst_valid", 32'(valid), 0);
        step_n = 1'b1;
        do_reset(2);
        chk("final_ops", 32'({OpA, OpB}), 32'(rom[0]));

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
